rsa_host_seq: RTL and testbench
===============================

// Module: rsa_host_seq
// PURPOSE
//  Host-side initiator for the RSA accelerator's shared 32-bit load/readback bus.
//  On start, resets the accelerator port and issues the 5-beat write sequence (dummy, base, exponent,
//  modulus, go). It then waits for the end flag, asserts the output enable and captures the result.
//  Sits between a test controller/CPU and the accelerator I/O block; one transaction at a time.
// PARAMETERS
//  WIDTH        32     bus/operand width
//  RST_CYC      4      cycles rsp_rstn held low, then same count of recovery high
//  SETUP_CYC    2      cycles data driven before write rises (also hold after write falls)
//  PULSE_CYC    4      cycles write held high per beat (>=2; far side edge-detects write)
//  GAP_CYC      4      cycles write held low between beats
//  READ_CYC     3      cycles oe held high before result sampled
//  TIMEOUT_CYC  65535  max cycles waiting for io_end
// PORTS
//  clk        in   1      clock
//  rstn       in   1      synchronous active-low reset
//  start      in   1      1-cycle request; sampled in IDLE only
//  base_in    in   WIDTH  base operand
//  exp_in     in   WIDTH  exponent operand
//  mod_in     in   WIDTH  modulus operand
//  io_end     in   1      accelerator computation-complete level
//  data_in    in   WIDTH  bus value read while oe=1
//  data_out   out  WIDTH  bus value to drive
//  data_oe    out  1      host drives bus when 1
//  rsp_rstn   out  1      accelerator reset, active low
//  write      out  1      accelerator write strobe (level)
//  oe         out  1      accelerator output enable
//  busy       out  1      transaction in progress
//  done       out  1      1-cycle pulse: result valid
//  timeout    out  1      1-cycle pulse: io_end not seen within TIMEOUT_CYC
//  result     out  WIDTH  captured result, held until next capture or reset
// BEHAVIOUR
//  Reset (rstn=0 at posedge): state IDLE; rsp_rstn=0, all other outputs 0, result=0, counters 0.
//  FSM: IDLE->ARST->ARCV->SETUP->PULSE->HOLD->GAP->(SETUP next beat | WAIT)->READ->IDLE; WAIT->IDLE on timeout.
//  IDLE: rsp_rstn=1, busy=0. start=1 latches base_in/exp_in/mod_in, beat=0, ->ARST; busy=1 next cycle.
//  ARST: rsp_rstn=0 for RST_CYC cycles. ARCV: rsp_rstn=1 for RST_CYC cycles.
//  Beat data: 0->32'h0, 1->base, 2->exponent, 3->modulus, 4->32'h0; data_out held in SETUP..HOLD.
//  SETUP: data_oe=1, write=0, SETUP_CYC cycles. PULSE: write=1, PULSE_CYC cycles.
//  HOLD: write=0, data stable, SETUP_CYC cycles. GAP: data_oe=0, GAP_CYC cycles; beat++.
//  After beat 4 GAP -> WAIT; timer cleared on entry.
//  WAIT: all drives 0. io_end=1 -> READ. Timer reaches TIMEOUT_CYC-1 without io_end -> timeout=1, ->IDLE.
//  io_end and timer expiry on the same cycle: io_end wins.
//  READ: oe=1, data_oe=0 for READ_CYC cycles; last cycle result<=data_in, done=1, ->IDLE, oe=0 next cycle.
//  Invariant: data_oe and oe never both 1 in any cycle; write only 1 while data_oe=1.
//  start while busy: ignored, no queuing. Operand inputs may change after the start cycle.
//  Reset mid-transaction: aborts next edge to reset values; result cleared; no done/timeout pulse.
//  io_end before beat 4 completes: ignored (only examined in WAIT).
//  Counters sized for the largest parameter; no wrap inside a phase.
// TESTING
//  1. start with base=0x032178C4, exp=0x11, mod=0x07A50679; model returns 0x007DC743 -> result=0x007DC743, done 1 cycle.
//  2. Bus check: monitor 5 write pulses; data_out = 0, base, exp, mod, 0 during each pulse; data_oe&oe never both 1.
//  3. io_end never asserted -> timeout pulse exactly TIMEOUT_CYC cycles after WAIT entry; busy=0, result unchanged.
//  4. start pulses during beat 2 and WAIT -> ignored; exactly one done; operand change after start has no effect.
//  5. rstn=0 during PULSE of beat 3 -> next cycle write=0, data_oe=0, rsp_rstn=0, busy=0, result=0.
//  6. Back-to-back: start in the cycle after done -> new ARST phase runs; second result captured.

Source files
------------

// File: rtl/rsa_host_seq.sv
// Host-side sequencer for the RSA accelerator load/readback bus: resets the far side,
// writes the five operand beats, waits for completion and captures the result.
module rsa_host_seq #(
  parameter int WIDTH       = 32,
  parameter int RST_CYC     = 4,
  parameter int SETUP_CYC   = 2,
  parameter int PULSE_CYC   = 4,
  parameter int GAP_CYC     = 4,
  parameter int READ_CYC    = 3,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] base_in,
  input  logic [WIDTH-1:0] exp_in,
  input  logic [WIDTH-1:0] mod_in,
  input  logic             io_end,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_oe,
  output logic             rsp_rstn,
  output logic             write,
  output logic             oe,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [WIDTH-1:0] result
);

  localparam int M1   = (RST_CYC > SETUP_CYC) ? RST_CYC : SETUP_CYC;
  localparam int M2   = (M1 > PULSE_CYC) ? M1 : PULSE_CYC;
  localparam int M3   = (M2 > GAP_CYC) ? M2 : GAP_CYC;
  localparam int M4   = (M3 > READ_CYC) ? M3 : READ_CYC;
  localparam int MAXC = (M4 > TIMEOUT_CYC) ? M4 : TIMEOUT_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] READ_LAST  = CW'(READ_CYC - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYC - 1);
  localparam logic [2:0]    BEAT_LAST  = 3'd4;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_ARST  = 4'd1;
  localparam logic [3:0] S_ARCV  = 4'd2;
  localparam logic [3:0] S_SETUP = 4'd3;
  localparam logic [3:0] S_PULSE = 4'd4;
  localparam logic [3:0] S_HOLD  = 4'd5;
  localparam logic [3:0] S_GAP   = 4'd6;
  localparam logic [3:0] S_WAIT  = 4'd7;
  localparam logic [3:0] S_READ  = 4'd8;

  logic [3:0]       state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [2:0]       beat, beat_n;
  logic [WIDTH-1:0] base_q, exp_q, mod_q;
  logic [WIDTH-1:0] beat_word;
  logic             fire_done, fire_to, drive_n;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    beat_n    = beat;
    fire_done = 1'b0;
    fire_to   = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (start) begin
          state_n = S_ARST;
          beat_n  = 3'd0;
        end
      end
      S_ARST:  if (cnt == RST_LAST)   begin state_n = S_ARCV;  cnt_n = '0; end
      S_ARCV:  if (cnt == RST_LAST)   begin state_n = S_SETUP; cnt_n = '0; end
      S_SETUP: if (cnt == SETUP_LAST) begin state_n = S_PULSE; cnt_n = '0; end
      S_PULSE: if (cnt == PULSE_LAST) begin state_n = S_HOLD;  cnt_n = '0; end
      S_HOLD:  if (cnt == SETUP_LAST) begin state_n = S_GAP;   cnt_n = '0; end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n = '0;
          if (beat == BEAT_LAST) begin
            state_n = S_WAIT;
          end else begin
            state_n = S_SETUP;
            beat_n  = beat + 3'd1;
          end
        end
      end
      S_WAIT: begin
        // Completion takes priority over expiry when both land on the same cycle.
        if (io_end) begin
          state_n = S_READ;
          cnt_n   = '0;
        end else if (cnt == TO_LAST) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          fire_to = 1'b1;
        end
      end
      S_READ: begin
        if (cnt == READ_LAST) begin
          state_n   = S_IDLE;
          cnt_n     = '0;
          fire_done = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    case (beat_n)
      3'd1:    beat_word = base_q;
      3'd2:    beat_word = exp_q;
      3'd3:    beat_word = mod_q;
      default: beat_word = '0;
    endcase
    drive_n = (state_n == S_SETUP) || (state_n == S_PULSE) || (state_n == S_HOLD);
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      beat     <= 3'd0;
      base_q   <= '0;
      exp_q    <= '0;
      mod_q    <= '0;
      data_out <= '0;
      data_oe  <= 1'b0;
      rsp_rstn <= 1'b0;
      write    <= 1'b0;
      oe       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      result   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      beat  <= beat_n;
      if (state == S_IDLE && start) begin
        base_q <= base_in;
        exp_q  <= exp_in;
        mod_q  <= mod_in;
      end
      data_out <= drive_n ? beat_word : '0;
      data_oe  <= drive_n;
      rsp_rstn <= (state_n != S_ARST);
      write    <= (state_n == S_PULSE);
      oe       <= (state_n == S_READ);
      busy     <= (state_n != S_IDLE);
      done     <= fire_done;
      timeout  <= fire_to;
      if (fire_done) result <= data_in;
    end
  end

endmodule

// File: tb/tb_rsa_host_seq.sv
// Bench for rsa_host_seq: a transaction-timeline model checked every cycle, a write-beat
// scoreboard, and directed scenarios with literal expectations.
module tb_rsa_host_seq;

  localparam int W       = 32;
  localparam int RST     = 4;
  localparam int SETUP   = 2;
  localparam int PULSE   = 4;
  localparam int GAP     = 4;
  localparam int READ    = 3;
  localparam int TO      = 300;
  localparam int BEAT_LEN = 2 * SETUP + PULSE + GAP;
  localparam int L_PRE   = 2 * RST + 5 * BEAT_LEN;

  localparam int PH_RST  = 0;
  localparam int PH_IDLE = 1;
  localparam int PH_SEQ  = 2;
  localparam int PH_WAIT = 3;
  localparam int PH_READ = 4;

  logic         clk = 1'b0;
  logic         rstn, start, io_end;
  logic [W-1:0] base_in, exp_in, mod_in, data_in;
  logic [W-1:0] data_out, result;
  logic         data_oe, rsp_rstn, write, oe, busy, done, timeout;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [W-1:0] exp_q[$];

  rsa_host_seq #(
    .WIDTH(W), .RST_CYC(RST), .SETUP_CYC(SETUP), .PULSE_CYC(PULSE),
    .GAP_CYC(GAP), .READ_CYC(READ), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_in(base_in), .exp_in(exp_in),
    .mod_in(mod_in), .io_end(io_end), .data_in(data_in), .data_out(data_out),
    .data_oe(data_oe), .rsp_rstn(rsp_rstn), .write(write), .oe(oe), .busy(busy),
    .done(done), .timeout(timeout), .result(result)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // ---------------- model + compare ----------------
  int           m_ph = PH_RST;
  int           m_k, m_w, m_r;
  logic [W-1:0] m_res = '0;
  logic [W-1:0] m_words[5];
  logic         m_done, m_to;
  logic         prev_wr = 1'b0;

  always @(posedge clk) begin
    logic         e_rsp, e_doe, e_wr, e_oe, e_busy;
    logic [W-1:0] e_dout, popped;
    int           j, bt, o;
    m_done = 1'b0;
    m_to   = 1'b0;
    if (!rstn) begin
      m_ph = PH_RST;
      m_res = '0;
      exp_q.delete();
    end else begin
      case (m_ph)
        PH_RST, PH_IDLE: begin
          if (start) begin
            m_ph = PH_SEQ;
            m_k  = 0;
            m_words[0] = '0;
            m_words[1] = base_in;
            m_words[2] = exp_in;
            m_words[3] = mod_in;
            m_words[4] = '0;
            for (int i = 0; i < 5; i++) exp_q.push_back(m_words[i]);
          end else begin
            m_ph = PH_IDLE;
          end
        end
        PH_SEQ: begin
          m_k++;
          if (m_k == L_PRE) begin
            m_ph = PH_WAIT;
            m_w  = 0;
          end
        end
        PH_WAIT: begin
          if (io_end) begin
            m_ph = PH_READ;
            m_r  = 0;
          end else if (m_w + 1 == TO) begin
            m_to = 1'b1;
            m_ph = PH_IDLE;
          end else begin
            m_w++;
          end
        end
        default: begin
          if (m_r + 1 == READ) begin
            m_done = 1'b1;
            m_res  = data_in;
            m_ph   = PH_IDLE;
          end else begin
            m_r++;
          end
        end
      endcase
    end

    e_rsp = (m_ph != PH_RST);
    e_doe = 1'b0; e_wr = 1'b0; e_oe = 1'b0; e_dout = '0;
    e_busy = (m_ph == PH_SEQ) || (m_ph == PH_WAIT) || (m_ph == PH_READ);
    if (m_ph == PH_SEQ) begin
      if (m_k < RST) e_rsp = 1'b0;
      if (m_k >= 2 * RST) begin
        j  = m_k - 2 * RST;
        bt = j / BEAT_LEN;
        o  = j % BEAT_LEN;
        e_doe  = (o < 2 * SETUP + PULSE);
        e_wr   = (o >= SETUP) && (o < SETUP + PULSE);
        e_dout = e_doe ? m_words[bt] : '0;
      end
    end
    if (m_ph == PH_READ) e_oe = 1'b1;

    #1;
    chk("rsp_rstn", W'(rsp_rstn), W'(e_rsp));
    chk("data_oe",  W'(data_oe),  W'(e_doe));
    chk("write",    W'(write),    W'(e_wr));
    chk("data_out", data_out,     e_dout);
    chk("oe",       W'(oe),       W'(e_oe));
    chk("busy",     W'(busy),     W'(e_busy));
    chk("done",     W'(done),     W'(m_done));
    chk("timeout",  W'(timeout),  W'(m_to));
    chk("result",   result,       m_res);
    chk("oe_excl",  W'(data_oe & oe), '0);
    chk("wr_drv",   W'(write & ~data_oe), '0);
    if (done) done_cnt++;
    if (rstn && write && !prev_wr) begin
      if (exp_q.size() == 0) begin
        chk("beat_unexpected", data_out, ~data_out);
      end else begin
        popped = exp_q.pop_front();
        chk("beat_word", data_out, popped);
      end
    end
    prev_wr = rstn ? write : 1'b0;
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m);
    @(negedge clk);
    base_in = b; exp_in = e; mod_in = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_pulse(input bit want_to, input int limit, output int cyc);
    bit seen = 1'b0;
    cyc = -1;
    for (int i = 1; i <= limit && !seen; i++) begin
      @(negedge clk);
      if (want_to ? timeout : done) begin
        seen = 1'b1;
        cyc  = i;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_%s: no pulse within %0d cycles", want_to ? "timeout" : "done", limit);
    end
  endtask

  task automatic set_end(input logic [W-1:0] val);
    data_in = val;
    io_end  = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int cyc, dc0;
    rstn = 1'b0; start = 1'b0; io_end = 1'b0;
    base_in = '0; exp_in = '0; mod_in = '0; data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_rsp_rstn", W'(rsp_rstn), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_result", result, '0);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_rsp_rstn", W'(rsp_rstn), 32'd1);

    // Basic transaction with known accelerator answer
    do_start(32'h032178C4, 32'h11, 32'h07A50679);
    repeat (L_PRE + 5) @(negedge clk);
    set_end(32'h007DC743);
    wait_pulse(1'b0, 200, cyc);
    io_end = 1'b0;
    chk("t1_result", result, 32'h007DC743);
    @(negedge clk);
    chk("t1_done_width", W'(done), '0);
    chk("t1_busy_after", W'(busy), '0);

    // Timeout: io_end never arrives
    repeat (2) @(negedge clk);
    do_start(32'h1111_2222, 32'h3333_4444, 32'h5555_6666);
    wait_pulse(1'b1, 1000, cyc);
    chk("t3_latency", W'(cyc), 32'd368);
    chk("t3_busy", W'(busy), '0);
    chk("t3_result_held", result, 32'h007DC743);

    // Ignored starts and operand changes after acceptance
    repeat (2) @(negedge clk);
    dc0 = done_cnt;
    do_start(32'hCAFE_0001, 32'h0000_0003, 32'h0BAD_F00D);
    base_in = 32'hDEAD_BEEF; exp_in = 32'h7777_7777; mod_in = 32'h1234_5678;
    repeat (36) @(negedge clk);
    chk("t4_in_pulse", W'(write), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (L_PRE - 37 + 2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    set_end(32'h0042_4242);
    wait_pulse(1'b0, 50, cyc);
    io_end = 1'b0;
    repeat (10) @(negedge clk);
    chk("t4_one_done", W'(done_cnt - dc0), 32'd1);
    chk("t4_result", result, 32'h0042_4242);
    chk("t4_no_restart", W'(busy), '0);

    // Reset during the beat-3 write pulse
    do_start(32'hAAAA_0000, 32'hBBBB_0000, 32'hCCCC_0000);
    repeat (47) @(negedge clk);
    chk("t5_pre_write", W'(write), 32'd1);
    chk("t5_pre_word", data_out, 32'hCCCC_0000);
    rstn = 1'b0;
    @(negedge clk);
    chk("t5_write", W'(write), '0);
    chk("t5_data_oe", W'(data_oe), '0);
    chk("t5_rsp_rstn", W'(rsp_rstn), '0);
    chk("t5_busy", W'(busy), '0);
    chk("t5_result", result, '0);
    rstn = 1'b1;
    @(negedge clk);

    // Early io_end (held from beat 1), then a back-to-back transaction
    do_start(32'h0000_0005, 32'h0000_0007, 32'h0000_000B);
    repeat (20) @(negedge clk);
    set_end(32'h0000_0003);
    wait_pulse(1'b0, 200, cyc);
    chk("t6_early_latency", W'(cyc + 20), 32'd72);
    chk("t6_first_result", result, 32'h0000_0003);
    io_end = 1'b0;
    do_start(32'h1357_9BDF, 32'h0002_0001, 32'h7FFF_FFFF);
    chk("t6_new_arst", W'(rsp_rstn), '0);
    chk("t6_busy", W'(busy), 32'd1);
    repeat (L_PRE + 2) @(negedge clk);
    set_end(32'hA5A5_5A5A);
    wait_pulse(1'b0, 50, cyc);
    io_end = 1'b0;
    chk("t6_second_result", result, 32'hA5A5_5A5A);
    repeat (3) @(negedge clk);
    chk("beats_drained", W'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
